field_scanner: RTL and testbench
================================

// Module: field_scanner
// PURPOSE
//  Display-side reader of the game field. Scans the visible rows of the colour-field RAM through the
//  game's output read port and composites the falling piece on top. Shifts each row serially into a
//  HUB75-style LED matrix (RGB, shift clock, latch, output-enable, row address).
//  Sits between the game block and the panel pins.
// PARAMETERS
//  ROWS     24   visible field rows scanned (RAM addr 0..ROWS-1)
//  COLS     10   cells per row; 3-bit colour per cell, cell c = rd_data[3c+:3]
//  CLK_DIV  2    clk cycles per panel_sclk half-period (>=1)
//  ON_TIME  256  clk cycles panel_oe_n held low per row (>=1)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   reset
//  rd_addr      out  5   field RAM read address
//  rd_data      in   30  field RAM row data, valid 1 clk after rd_addr (registered RAM)
//  piece_bits   in   16  falling-piece mask; nibble r = piece row r, bit k = column piece_x+k
//  piece_index  in   3   falling-piece colour code (1..7)
//  piece_x      in   4   piece column origin
//  piece_y      in   5   piece row origin
//  game_busy    in   1   high while the game is updating its field/piece registers
//  panel_rgb    out  3   pixel colour for current shift position
//  panel_sclk   out  1   panel shift clock; panel samples panel_rgb on rising edge
//  panel_lat    out  1   row latch pulse
//  panel_oe_n   out  1   panel output enable, active low
//  panel_row    out  5   row address shown on the panel
//  frame_start  out  1   one-clk pulse at start of each frame (row 0 READ)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low (clk, rst_n). Reset values: rd_addr=0, panel_rgb=0,
//    panel_sclk=0, panel_lat=0, panel_oe_n=1, panel_row=0, frame_start=0; FSM=READ, row=0.
//    Reset mid-operation aborts immediately; scan restarts at row 0 with a fresh frame_start.
//  - FSM: READ -> CAPTURE -> SHIFT (COLS pixels) -> LATCH -> DISPLAY -> READ.
//  - READ (1 clk): rd_addr<=row. If row==0: frame_start=1; if game_busy==0, snapshot piece_* into
//    internal registers, else keep previous snapshot (no tearing within a frame).
//  - CAPTURE (1 clk): load 30-bit row buffer = rd_data with overlay applied (see CONFIGURATION).
//  - SHIFT: cell 0 first. Per pixel: panel_rgb<=cell, sclk low CLK_DIV clks, then high CLK_DIV clks;
//    rgb stable across the rising edge. sclk returns low after the last pixel. oe_n stays 1.
//  - LATCH (1 clk): panel_lat=1, panel_row<=row, panel_oe_n=1.
//  - DISPLAY (ON_TIME clks): panel_oe_n=0, lat=0; on exit oe_n<=1, row<=row+1, wrapping ROWS-1 -> 0.
//  - Row period = 3 + 2*CLK_DIV*COLS + ON_TIME clks (defaults: 299); frame = ROWS row periods.
//  - Overlay rule: r = row - piece_y (5-bit); piece row valid only when row>=piece_y and r<4.
//    Cell c is covered when k=c-piece_x is 0..3 and piece_bits[4r+k]=1; covered colour := piece_index.
//    Mask bits mapping to c>=COLS or row>=ROWS are dropped (no wrap into next row/column).
//  - rd_addr only changes in READ; RAM contents changing mid-row are not re-read.
// CONFIGURATION
//  PIECE_OVERLAY_EN defined: falling-piece overlay applied as above; piece_* and game_busy used.
//  PIECE_OVERLAY_EN undefined: row buffer = rd_data unchanged; piece_* and game_busy ignored; no
//    snapshot registers; timing identical.
// STRUCTURE
//  - matrix_pkg: COLS, ROWS, CELL_W=3, colour codes (BLACK=0, I=1..L=7), FSM state encoding.
//  - Sub-module row_overlay (combinational): rd_data, row, snapshot piece -> composited 30-bit row;
//    instanced only under PIECE_OVERLAY_EN.
// TESTING
//  1. Release rst_n -> oe_n=1, rd_addr=0, frame_start one-clk pulse; rd_addr steps 0..23 every 299 clks,
//     23 wraps to 0 with next frame_start.
//  2. Row 5 data=30'h2 (cell0=3'b010), piece_y=28 -> panel row 5: rgb=010 at 1st sclk rise, 000 for 9;
//     lat pulse then oe_n low exactly 256 clks with panel_row=5.
//  3. OVERLAY_EN, piece_bits=16'h0033, index=5, x=3, y=4, RAM zero -> rows 4,5 cells 3,4 rgb=101;
//     all other cells 000; nonzero RAM under those cells is overridden.
//  4. piece_x=8, bits=16'h000F, y=0 -> row 0 cells 8,9 = piece colour; bits for cells 10,11 dropped.
//  5. game_busy=1 at row 0 READ, piece_y changed 2->6 mid-frame -> frame still shows y=2; next frame
//     with busy=0 shows y=6.
//  6. rst_n low during row 7 SHIFT -> outputs at reset values same cycle; after release scan resumes
//     at row 0; overlay undefined build shows raw RAM for test 3 stimulus.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants, colour codes and scan FSM encoding for the LED field scanner.
package matrix_pkg;
  localparam int ROWS   = 24;
  localparam int COLS   = 10;
  localparam int CELL_W = 3;
  localparam int ROW_W  = COLS * CELL_W;
  localparam int ADDR_W = 5;

  typedef enum logic [2:0] {
    BLACK = 3'd0,
    COL_I = 3'd1,
    COL_O = 3'd2,
    COL_T = 3'd3,
    COL_S = 3'd4,
    COL_Z = 3'd5,
    COL_J = 3'd6,
    COL_L = 3'd7
  } colour_t;

  typedef enum logic [2:0] {
    ST_READ,
    ST_CAPTURE,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } scan_state_t;

  function automatic logic [CELL_W-1:0] cell_of(input logic [ROW_W-1:0] row_data,
                                                input logic [3:0] idx);
    logic [ROW_W-1:0] shifted;
    shifted = row_data >> (int'(idx) * CELL_W);
    return shifted[CELL_W-1:0];
  endfunction
endpackage

// File: rtl/row_overlay.sv
// Composites the snapshotted falling piece onto one raw field row (purely combinational).
module row_overlay
  import matrix_pkg::*;
(
  input  logic [ROW_W-1:0]  raw_row,
  input  logic [ADDR_W-1:0] row,
  input  logic [15:0]       piece_bits,
  input  logic [2:0]        piece_index,
  input  logic [3:0]        piece_x,
  input  logic [4:0]        piece_y,
  output logic [ROW_W-1:0]  comp_row
);
  logic [4:0] rel_row;
  logic [4:0] rel_col;
  logic       row_hit;

  // Mask columns beyond the field are never visited, so they drop out instead of wrapping.
  always_comb begin
    comp_row = raw_row;
    rel_col  = '0;
    rel_row  = row - piece_y;
    row_hit  = (row >= piece_y) && (rel_row < 5'd4) && (row < 5'(ROWS));
    for (int c = 0; c < COLS; c++) begin
      rel_col = 5'(c) - {1'b0, piece_x};
      if (row_hit && (5'(c) >= {1'b0, piece_x}) && (rel_col < 5'd4) &&
          piece_bits[{rel_row[1:0], rel_col[1:0]}])
        comp_row[c*CELL_W +: CELL_W] = piece_index;
    end
  end
endmodule

// File: rtl/field_scanner.sv
// Scans field RAM rows out to a HUB75-style panel; the falling-piece overlay is built
// only when PIECE_OVERLAY_EN is defined.
module field_scanner
  import matrix_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int ON_TIME = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [4:0]  rd_addr,
  input  logic [29:0] rd_data,
  input  logic [15:0] piece_bits,
  input  logic [2:0]  piece_index,
  input  logic [3:0]  piece_x,
  input  logic [4:0]  piece_y,
  input  logic        game_busy,
  output logic [2:0]  panel_rgb,
  output logic        panel_sclk,
  output logic        panel_lat,
  output logic        panel_oe_n,
  output logic [4:0]  panel_row,
  output logic        frame_start
);
  localparam int CNT_MAX = (ON_TIME > CLK_DIV) ? ON_TIME : CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  scan_state_t      state, state_next;
  logic [4:0]       row;
  logic [3:0]       pix;
  logic [CNT_W-1:0] cnt;
  logic [ROW_W-1:0] row_buf;
  logic [ROW_W-1:0] comp_row;
  logic             div_done;
  logic             shift_done;
  logic             disp_done;

  // The registered RAM samples the address at the end of READ, so data is ready in CAPTURE.
  assign rd_addr    = row;
  assign div_done   = (cnt == CNT_W'(CLK_DIV - 1));
  assign shift_done = div_done && panel_sclk && (pix == 4'(COLS - 1));
  assign disp_done  = (cnt == CNT_W'(ON_TIME - 1));

`ifdef PIECE_OVERLAY_EN
  logic [15:0] snap_bits;
  logic [2:0]  snap_index;
  logic [3:0]  snap_x;
  logic [4:0]  snap_y;

  // Piece state is frozen once per frame so a frame never shows a half-updated piece.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_bits  <= '0;
      snap_index <= '0;
      snap_x     <= '0;
      snap_y     <= '0;
    end else if ((state == ST_READ) && (row == '0) && !game_busy) begin
      snap_bits  <= piece_bits;
      snap_index <= piece_index;
      snap_x     <= piece_x;
      snap_y     <= piece_y;
    end
  end

  row_overlay u_overlay (
    .raw_row    (rd_data),
    .row        (row),
    .piece_bits (snap_bits),
    .piece_index(snap_index),
    .piece_x    (snap_x),
    .piece_y    (snap_y),
    .comp_row   (comp_row)
  );
`else
  logic unused_piece;
  assign unused_piece = ^{piece_bits, piece_index, piece_x, piece_y, game_busy};
  assign comp_row     = rd_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_READ;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_READ:    state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_SHIFT;
      ST_SHIFT:   if (shift_done) state_next = ST_LATCH;
      ST_LATCH:   state_next = ST_DISPLAY;
      ST_DISPLAY: if (disp_done) state_next = ST_READ;
      default:    state_next = ST_READ;
    endcase
  end

  // One counter paces both the sclk half-periods and the display on-time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row         <= '0;
      pix         <= '0;
      cnt         <= '0;
      row_buf     <= '0;
      panel_rgb   <= '0;
      panel_sclk  <= 1'b0;
      panel_lat   <= 1'b0;
      panel_oe_n  <= 1'b1;
      panel_row   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= (state == ST_READ) && (row == '0);
      case (state)
        ST_CAPTURE: begin
          row_buf    <= comp_row;
          panel_rgb  <= comp_row[CELL_W-1:0];
          panel_sclk <= 1'b0;
          pix        <= '0;
          cnt        <= '0;
        end
        ST_SHIFT: begin
          if (!div_done) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (!panel_sclk) begin
              panel_sclk <= 1'b1;
            end else begin
              panel_sclk <= 1'b0;
              if (shift_done) begin
                panel_lat <= 1'b1;
                panel_row <= row;
              end else begin
                pix       <= pix + 4'd1;
                panel_rgb <= cell_of(row_buf, pix + 4'd1);
              end
            end
          end
        end
        ST_LATCH: begin
          panel_lat  <= 1'b0;
          panel_oe_n <= 1'b0;
          cnt        <= '0;
        end
        ST_DISPLAY: begin
          if (!disp_done) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt        <= '0;
            panel_oe_n <= 1'b1;
            row        <= (row == 5'(ROWS - 1)) ? 5'd0 : row + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_field_scanner.sv
// Scoreboard bench for field_scanner: expected panel rows are queued by the stimulus and
// checked by a monitor at each row latch; also checks frame/row timing and reset behaviour.
module tb_field_scanner;
  localparam int ROW_CYC   = 3 + 2 * 2 * 10 + 256;
  localparam int FRAME_CYC = 24 * ROW_CYC;

`ifdef PIECE_OVERLAY_EN
  localparam logic [29:0] EXP_F1_R4 = 30'h0000_5A00;
  localparam logic [29:0] EXP_F1_R5 = 30'h0000_5A02;
  localparam logic [29:0] EXP_B_R0  = 30'h1B00_0000;
  localparam logic [29:0] EXP_F4_R6 = 30'h0000_0006;
`else
  localparam logic [29:0] EXP_F1_R4 = 30'h0000_0E00;
  localparam logic [29:0] EXP_F1_R5 = 30'h0000_0002;
  localparam logic [29:0] EXP_B_R0  = 30'h0000_0000;
  localparam logic [29:0] EXP_F4_R6 = 30'h0000_0000;
`endif

  typedef struct {
    int          frame;
    int          row;
    logic [29:0] pix;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_addr;
  logic [29:0] rd_data = '0;
  logic [15:0] piece_bits;
  logic [2:0]  piece_index;
  logic [3:0]  piece_x;
  logic [4:0]  piece_y;
  logic        game_busy;
  logic [2:0]  panel_rgb;
  logic        panel_sclk;
  logic        panel_lat;
  logic        panel_oe_n;
  logic [4:0]  panel_row;
  logic        frame_start;

  logic [29:0] mem [24];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          frame_no = 0;

  field_scanner #(.CLK_DIV(2), .ON_TIME(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .piece_bits (piece_bits),
    .piece_index(piece_index),
    .piece_x    (piece_x),
    .piece_y    (piece_y),
    .game_busy  (game_busy),
    .panel_rgb  (panel_rgb),
    .panel_sclk (panel_sclk),
    .panel_lat  (panel_lat),
    .panel_oe_n (panel_oe_n),
    .panel_row  (panel_row),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_data <= mem[rd_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] bits, input logic [2:0] idx,
                               input logic [3:0] x, input logic [4:0] y, input logic busy);
    piece_bits  = bits;
    piece_index = idx;
    piece_x     = x;
    piece_y     = y;
    game_busy   = busy;
  endtask

  task automatic expectRow(input int frame, input int row, input logic [29:0] pix);
    exp_t e;
    e.frame = frame;
    e.row   = row;
    e.pix   = pix;
    exp_q.push_back(e);
  endtask

  task automatic waitFrame(input int target);
    int n = 0;
    while (frame_no < target && n < 8000) begin
      @(negedge clk);
      n++;
    end
    if (frame_no < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_frame: frame_no=%0d, required %0d", frame_no, target);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    checkOutput({tag, "_rgb"}, 32'(panel_rgb), 32'd0);
    checkOutput({tag, "_sclk"}, 32'(panel_sclk), 32'd0);
    checkOutput({tag, "_lat"}, 32'(panel_lat), 32'd0);
    checkOutput({tag, "_oe_n"}, 32'(panel_oe_n), 32'd1);
    checkOutput({tag, "_row"}, 32'(panel_row), 32'd0);
    checkOutput({tag, "_frame_start"}, 32'(frame_start), 32'd0);
  endtask

  // Monitor: collects shifted pixels, checks timing, and pops the scoreboard at each latch.
  initial begin
    logic [29:0] shift_buf = '0;
    int          pix_idx = 0;
    logic        sclk_prev = 1'b0;
    logic [2:0]  rgb_prev = '0;
    logic        fs_prev = 1'b0;
    logic        fs_valid = 1'b0;
    int          fs_cyc = 0;
    logic [4:0]  addr_prev = '0;
    logic        addr_valid = 1'b0;
    int          addr_cyc = 0;
    logic        armed = 1'b0;
    int          oe_cnt = 0;
    logic [4:0]  lat_row = '0;
    logic        row_moved = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        pix_idx    = 0;
        sclk_prev  = 1'b0;
        fs_prev    = 1'b0;
        fs_valid   = 1'b0;
        addr_prev  = '0;
        addr_valid = 1'b0;
        armed      = 1'b0;
        rgb_prev   = panel_rgb;
      end else begin
        if (frame_start) begin
          checkOutput("fs_rd_addr", 32'(rd_addr), 32'd0);
          checkOutput("fs_one_clk", 32'(fs_prev), 32'd0);
          if (fs_valid) checkOutput("frame_period", 32'(cyc - fs_cyc), 32'(FRAME_CYC));
          fs_valid = 1'b1;
          fs_cyc   = cyc;
          frame_no++;
        end
        if (rd_addr != addr_prev) begin
          checkOutput("rd_addr_step", 32'(rd_addr),
                      (addr_prev == 5'd23) ? 32'd0 : 32'(addr_prev) + 32'd1);
          if (addr_valid) checkOutput("row_period", 32'(cyc - addr_cyc), 32'(ROW_CYC));
          addr_valid = 1'b1;
          addr_cyc   = cyc;
          addr_prev  = rd_addr;
        end
        if (panel_sclk && !sclk_prev) begin
          checkOutput("rgb_stable", 32'(panel_rgb), 32'(rgb_prev));
          if (pix_idx < 10) shift_buf[pix_idx*3 +: 3] = panel_rgb;
          pix_idx++;
        end
        if (panel_lat) begin
          checkOutput("lat_oe_n", 32'(panel_oe_n), 32'd1);
          checkOutput("pix_count", 32'(pix_idx), 32'd10);
          while (exp_q.size() > 0 && (exp_q[0].frame < frame_no ||
                 (exp_q[0].frame == frame_no && exp_q[0].row < int'(panel_row)))) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL missed_row f%0d r%0d: not shown, expected %0h", e.frame, e.row, e.pix);
          end
          if (exp_q.size() > 0 && exp_q[0].frame == frame_no && exp_q[0].row == int'(panel_row)) begin
            e = exp_q.pop_front();
            checkOutput($sformatf("row%0d_f%0d_pixels", e.row, e.frame), 32'(shift_buf), 32'(e.pix));
          end
          armed     = 1'b1;
          oe_cnt    = 0;
          lat_row   = panel_row;
          row_moved = 1'b0;
          pix_idx   = 0;
          shift_buf = '0;
        end else if (armed) begin
          if (!panel_oe_n) begin
            oe_cnt++;
            if (panel_row != lat_row) row_moved = 1'b1;
          end else if (oe_cnt > 0) begin
            checkOutput("oe_low_cycles", 32'(oe_cnt), 32'd256);
            checkOutput("row_held_in_display", 32'(row_moved), 32'd0);
            armed = 1'b0;
          end
        end
        sclk_prev = panel_sclk;
        fs_prev   = frame_start;
        rgb_prev  = panel_rgb;
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    applyStimulus(16'h0033, 3'd5, 4'd3, 5'd4, 1'b0);
    for (int r = 0; r < 24; r++) mem[r] = '0;
    mem[4]  = 30'h0000_0E00;
    mem[5]  = 30'h0000_0002;
    mem[7]  = 30'h0123_4567;
    mem[23] = 30'h3FFF_FFFF;
    repeat (3) @(negedge clk);
    checkResetValues("reset");

    expectRow(1, 0, 30'h0);
    expectRow(1, 4, EXP_F1_R4);
    expectRow(1, 5, EXP_F1_R5);
    expectRow(1, 7, 30'h0123_4567);
    expectRow(1, 23, 30'h3FFF_FFFF);
    rst_n = 1'b1;
    waitFrame(1);

    applyStimulus(16'h000F, 3'd3, 4'd8, 5'd0, 1'b0);
    expectRow(2, 0, EXP_B_R0);
    expectRow(2, 1, 30'h0);
    expectRow(2, 5, 30'h0000_0002);
    waitFrame(2);

    applyStimulus(16'h0001, 3'd6, 4'd0, 5'd6, 1'b1);
    expectRow(3, 0, EXP_B_R0);
    expectRow(3, 6, 30'h0);
    waitFrame(3);

    applyStimulus(16'h0001, 3'd6, 4'd0, 5'd6, 1'b0);
    expectRow(4, 0, 30'h0);
    expectRow(4, 6, EXP_F4_R6);
    waitFrame(4);

    n = 0;
    while (!(rd_addr == 5'd7 && panel_sclk) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_row7_shift", 32'(n < 4000), 32'd1);
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    repeat (2) @(negedge clk);
    expectRow(frame_no + 1, 0, 30'h0);
    expectRow(frame_no + 1, 7, 30'h0123_4567);
    rst_n = 1'b1;
    waitFrame(frame_no + 1);
    waitFrame(frame_no + 1);

    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL unshown_row f%0d r%0d: not shown, expected %0h", e.frame, e.row, e.pix);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
